csa_accumulator: RTL
====================

# csa_accumulator

Parametrised, sequential multi-operand accumulator built on carry-save addition. Accepts a stream of N-bit operands over a valid/ready handshake and keeps the running total in redundant sum/carry form, so each operand costs one CSA level and no carry propagation. On the last operand, or when the term limit is reached, it resolves the total with a chunked carry-propagate adder over several cycles. It then presents the exact W-bit result downstream. It sits behind partial-product generators in the multiplier datapaths and in dot-product/MAC paths.

## Interface
- N, 32, operand width in bits
- MAX_TERMS, 16, maximum operands per packet (≥2)
- CHUNK, 8, bits resolved per cycle by the final adder (1..W)
- SIGNED, 0, 1 = operands sign-extended to W, 0 = zero-extended
- Derived: W = N + $clog2(MAX_TERMS); R = ceil(W/CHUNK); CW = $clog2(MAX_TERMS+1)

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  accumulator can take an operand
- in_data  in  N  operand
- in_last  in  1  marks the final operand of a packet; qualified by in_valid && in_ready
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  W  resolved sum, modulo 2^W; exact given the guard bits
- out_count  out  CW  number of operands in the packet (1..MAX_TERMS)

## Operation
- Internal registers:
  - S[W-1:0], C[W-1:0]: redundant total
  - cnt[CW-1:0]: operand count
  - k: chunk index
  - cy: chunk carry
  - res[W-1:0]: result
- States are ACCUM, RESOLVE and DONE. Reset state is ACCUM.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - On accept, let X = ext(in_data), where ext is sign- or zero-extension to W per SIGNED.
  - S ← S^C^X.
  - C ← {maj(S,C,X)[W-2:0],1'b0}. The carry out of bit W-1 is discarded, so the arithmetic is mod 2^W.
  - cnt ← cnt+1.
  - If in_last=1, or the accepted operand is the MAX_TERMS-th: go to RESOLVE with k←0 and cy←0.
- RESOLVE:
  - in_ready=0.
  - Each cycle, res[k-th chunk] ← S_chunk + C_chunk + cy. cy ← chunk carry-out. k ← k+1.
  - The top chunk may be narrower than CHUNK; its carry-out is discarded.
  - After chunk R-1: go to DONE.
- DONE:
  - out_valid=1. out_sum=res and out_count=cnt, both held stable.
  - in_ready=0; in_valid is ignored.
  - On out_valid && out_ready: clear S, C, cnt and res, then go to ACCUM.
- in_last on a cycle where in_ready=0 has no effect.
- There are no empty packets; every packet carries at least one operand.
- Reset, asserted at any time including mid-RESOLVE or in DONE:
  - Immediately forces ACCUM and clears S, C, cnt, k, cy and res.
  - Outputs during reset: in_ready=1, out_valid=0, out_sum=0, out_count=0.
  - A partial packet is lost.
- out_sum and out_count read 0 whenever the state is not DONE.

## Timing
- Throughput: one operand per cycle while in ACCUM.
- Latency: the closing operand is accepted at edge t. out_valid rises after edge t+R, i.e. R cycles later. Default parameters give R=5.
- Result handshake: accepted at edge u, so ACCUM is entered at u. in_ready is high in the following cycle.
- Minimum packet-to-packet spacing is R+1 cycles plus downstream stall.
- Outputs are registered or decoded from state only. There is no combinational path from in_* or out_ready to any output.
- in_ready depends only on state, so it has no dependency on in_valid.

## Test plan
- Unsigned accumulate (SIGNED=0, defaults): operands 5, 7, 9 with in_last on 9 → out_sum=21 and out_count=3. out_valid rises exactly 5 cycles after the edge that accepts 9, and in_ready stays 0 from that edge until the result handshake.
- Term limit: 16 operands of 0xFFFFFFFF, no in_last → auto-resolve after the 16th; out_sum=0xF_FFFF_FFF0 and out_count=16. A 17th in_valid is stalled (in_ready=0) until the result is taken.
- Signed mode (SIGNED=1):
  - -1, -2, 3 (last) → out_sum=0.
  - Single operand -5 with in_last → out_sum=0xF_FFFF_FFFB and out_count=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 → out_sum and out_count stable, in_ready=0, no operand absorbed. Release out_ready, then send 1, 2 (last) → out_sum=3.
- Reset mid-operation: assert rst_n=0 in the 3rd RESOLVE cycle → outputs go to reset values asynchronously. After release, packet 100, 200 (last) → out_sum=300 and out_count=2, with no residue from the aborted packet.
- Back-to-back packets: out_ready tied high; packets {1,1}, {2,2,2}, {0x80000000 ×2} → results 2, 6 and 0x1_0000_0000 in order. Each next operand is accepted the cycle after the result handshake.

Source files
------------

// File: rtl/csa_accumulator.sv
// Carry-save multi-operand accumulator.
// Operands are folded into a redundant sum/carry pair, one CSA level per
// operand. At the end of a packet a chunked ripple adder resolves the pair
// over R cycles, and the exact W-bit total is then held until downstream
// takes it.
module csa_accumulator #(
    parameter int N         = 32,
    parameter int MAX_TERMS = 16,
    parameter int CHUNK     = 8,
    parameter int SIGNED    = 0,
    localparam int W        = N + $clog2(MAX_TERMS),
    localparam int R        = (W + CHUNK - 1) / CHUNK,
    localparam int CW       = $clog2(MAX_TERMS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [N-1:0]  in_data_i,
    input  logic          in_last_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [W-1:0]  out_sum_o,
    output logic [CW-1:0] out_count_o
);

    localparam int G  = W - N;
    localparam int KW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   s_q, s_d;
    logic [W-1:0]   c_q, c_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [KW-1:0]  k_q, k_d;
    logic           cy_q, cy_d;
    logic [W-1:0]   res_q, res_d;

    // Operand extended to the full accumulator width (guard bits on top).
    logic [W-1:0]   x_w;
    generate
        if (SIGNED != 0) begin : g_sext
            assign x_w = {{G{in_data_i[N-1]}}, in_data_i};
        end else begin : g_zext
            assign x_w = {{G{1'b0}}, in_data_i};
        end
    endgenerate

    // Majority of the low W-1 bits only: the carry out of the top bit is
    // dropped, which keeps the redundant pair modulo 2^W.
    logic [W-2:0]   maj_lo;
    assign maj_lo = (s_q[W-2:0] & c_q[W-2:0])
                  | (s_q[W-2:0] & x_w[W-2:0])
                  | (c_q[W-2:0] & x_w[W-2:0]);

    // One adder per chunk position; only the chunk selected by k_q is
    // written back, so each position behaves as one ripple step in time.
    logic [R-1:0]   chunk_cy;
    logic [W-1:0]   res_resolve;
    genvar gi;
    generate
        for (gi = 0; gi < R; gi++) begin : g_chunk
            localparam int LO = gi * CHUNK;
            localparam int WI = ((W - LO) < CHUNK) ? (W - LO) : CHUNK;
            logic [WI:0] sum_w;
            assign sum_w = {1'b0, s_q[LO +: WI]} + {1'b0, c_q[LO +: WI]}
                         + {{WI{1'b0}}, cy_q};
            assign chunk_cy[gi] = sum_w[WI];
            assign res_resolve[LO +: WI] = (k_q == KW'(gi)) ? sum_w[WI-1:0]
                                                            : res_q[LO +: WI];
        end
    endgenerate

    // State register and datapath registers; reset abandons any packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            cy_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            cy_q    <= cy_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic: CSA fold in ACCUM, one chunk per cycle in RESOLVE,
    // hold and clear-on-handshake in DONE.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        cy_d    = cy_q;
        res_d   = res_q;
        case (state_q)
            ACCUM: begin
                if (in_valid_i) begin
                    s_d   = s_q ^ c_q ^ x_w;
                    c_d   = {maj_lo, 1'b0};
                    cnt_d = cnt_q + CW'(1);
                    if (in_last_i || (cnt_q == CW'(MAX_TERMS - 1))) begin
                        state_d = RESOLVE;
                        k_d     = '0;
                        cy_d    = 1'b0;
                    end
                end
            end
            RESOLVE: begin
                res_d = res_resolve;
                cy_d  = chunk_cy[k_q];
                k_d   = k_q + KW'(1);
                if (k_q == KW'(R - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    res_d   = '0;
                    k_d     = '0;
                    cy_d    = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // Outputs are decoded from state and registers only.
    assign in_ready_o  = (state_q == ACCUM);
    assign out_valid_o = (state_q == DONE);
    assign out_sum_o   = (state_q == DONE) ? res_q : '0;
    assign out_count_o = (state_q == DONE) ? cnt_q : '0;

endmodule
